// File: rtl/led_snake_pkg.sv
// Shared definitions for the LED-strip pipeline: default geometry and the
// pixel shifter state encoding.
package led_snake_pkg;

  localparam int LED_BITS_PER_PIXEL = 24;
  localparam int LED_NUM_LEDS       = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shifter_state_e;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_shifter_if.sv
// Pixel word handshake in, serial bit stream out, plus the per-bit feedback
// from the waveform stage.
interface pixel_shifter_if
  import led_snake_pkg::*;
#(
  parameter int BITS_PER_PIXEL = LED_BITS_PER_PIXEL
) ();

  logic [BITS_PER_PIXEL-1:0] pixel_data;
  logic                      pixel_valid;
  logic                      pixel_ready;
  logic                      bit_done;
  logic                      bit_to_transmit;
  logic                      bit_valid;
  logic                      all_bits_shifted;
  logic                      frame_done;

  modport slave (
    input  pixel_data,
    input  pixel_valid,
    input  bit_done,
    output pixel_ready,
    output bit_to_transmit,
    output bit_valid,
    output all_bits_shifted,
    output frame_done
  );

  modport master (
    output pixel_data,
    output pixel_valid,
    output bit_done,
    input  pixel_ready,
    input  bit_to_transmit,
    input  bit_valid,
    input  all_bits_shifted,
    input  frame_done
  );

endinterface

// File: rtl/pixel_shifter.sv
// Serialises one GRB word per LED, MSB first, advancing a bit per bit_done
// pulse and flagging end-of-word and end-of-frame.
module pixel_shifter
  import led_snake_pkg::*;
#(
  parameter int BITS_PER_PIXEL = LED_BITS_PER_PIXEL,
  parameter int NUM_LEDS       = LED_NUM_LEDS
) (
  input  logic             clk,
  input  logic             rstn,
  pixel_shifter_if.slave   bus
);

  localparam int BIT_W = cnt_width(BITS_PER_PIXEL);
  localparam int PIX_W = cnt_width(NUM_LEDS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_PER_PIXEL - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_LEDS - 1);

  shifter_state_e            state_q, state_d;
  logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [PIX_W-1:0]          pixel_cnt_q, pixel_cnt_d;
  logic                      all_bits_shifted_q, all_bits_shifted_d;
  logic                      frame_done_q, frame_done_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q            <= ST_IDLE;
      shift_q            <= '0;
      bit_cnt_q          <= '0;
      pixel_cnt_q        <= '0;
      all_bits_shifted_q <= 1'b0;
      frame_done_q       <= 1'b0;
    end else begin
      state_q            <= state_d;
      shift_q            <= shift_d;
      bit_cnt_q          <= bit_cnt_d;
      pixel_cnt_q        <= pixel_cnt_d;
      all_bits_shifted_q <= all_bits_shifted_d;
      frame_done_q       <= frame_done_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    shift_d            = shift_q;
    bit_cnt_d          = bit_cnt_q;
    pixel_cnt_d        = pixel_cnt_q;
    all_bits_shifted_d = 1'b0;
    frame_done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // bit_done has no meaning here; only a word transfer moves us on.
        if (bus.pixel_valid) begin
          shift_d   = bus.pixel_data;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.bit_done) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d            = ST_IDLE;
            all_bits_shifted_d = 1'b1;
            if (pixel_cnt_q == LAST_PIX) begin
              pixel_cnt_d  = '0;
              frame_done_d = 1'b1;
            end else begin
              pixel_cnt_d = pixel_cnt_q + PIX_W'(1);
            end
          end else begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The last word's MSB lingers in the register in IDLE, so mask it there.
  assign bus.pixel_ready      = (state_q == ST_IDLE);
  assign bus.bit_valid        = (state_q == ST_SHIFT);
  assign bus.bit_to_transmit  = (state_q == ST_SHIFT) & shift_q[BITS_PER_PIXEL-1];
  assign bus.all_bits_shifted = all_bits_shifted_q;
  assign bus.frame_done       = frame_done_q;

endmodule

// File: tb/tb_pixel_shifter.sv
// Directed checks of the pixel shifter: serial order, frame pulses,
// ignored inputs, final-bit load timing and mid-frame reset.
module tb_pixel_shifter;

  localparam int BPP   = 24;
  localparam int NLEDS = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pixel_shifter_if #(.BITS_PER_PIXEL(BPP)) bus ();

  pixel_shifter #(.BITS_PER_PIXEL(BPP), .NUM_LEDS(NLEDS)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int ash_seen = 0;
  int fd_seen  = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.all_bits_shifted) ash_seen++;
      if (bus.frame_done)       fd_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn            = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.bit_done    = 1'b0;
    bus.pixel_data  = '0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic pulse_done();
    bus.bit_done = 1'b1;
    tick();
    bus.bit_done = 1'b0;
  endtask

  task automatic load_word(input logic [BPP-1:0] w);
    bus.pixel_data  = w;
    bus.pixel_valid = 1'b1;
    for (int i = 0; i < 50 && !bus.pixel_ready; i++) tick();
    if (!bus.pixel_ready) begin
      total++; bad++;
      $display("FAIL load_timeout: pixel_ready=%0b required 1", bus.pixel_ready);
    end
    tick();
    bus.pixel_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn            = 1'b0;
    bus.pixel_valid = 1'b1;
    bus.pixel_data  = 24'hFFFFFF;
    bus.bit_done    = 1'b1;
    tick();
    tick();
    total++;
    if (bus.pixel_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b expected 1", bus.pixel_ready); end
    total++;
    if (bus.bit_valid !== 1'b0) begin bad++; $display("FAIL reset_bit_valid: got %0b expected 0", bus.bit_valid); end
    total++;
    if (bus.bit_to_transmit !== 1'b0) begin bad++; $display("FAIL reset_bit: got %0b expected 0", bus.bit_to_transmit); end
    total++;
    if (bus.all_bits_shifted !== 1'b0) begin bad++; $display("FAIL reset_ash: got %0b expected 0", bus.all_bits_shifted); end
    total++;
    if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %0b expected 0", bus.frame_done); end
    bus.pixel_valid = 1'b0;
    bus.bit_done    = 1'b0;
    rstn = 1'b1;
    tick();
    $display("test_reset: done");
  endtask

  task automatic test_serial();
    logic [23:0] exp_seq;
    int base;
    exp_seq = 24'b1010_0101_0000_1111_1100_0011;
    do_reset();
    base = ash_seen;
    load_word(24'hA5_0F_C3);
    for (int i = 0; i < 24; i++) begin
      total++;
      if (bus.bit_valid !== 1'b1 || bus.bit_to_transmit !== exp_seq[23-i]) begin
        bad++;
        $display("FAIL serial_bit%0d: got valid=%0b bit=%0b expected valid=1 bit=%0b",
                 i, bus.bit_valid, bus.bit_to_transmit, exp_seq[23-i]);
      end
      repeat (9) tick();
      total++;
      if (bus.bit_to_transmit !== exp_seq[23-i] || bus.all_bits_shifted !== 1'b0) begin
        bad++;
        $display("FAIL serial_hold%0d: got bit=%0b ash=%0b expected bit=%0b ash=0",
                 i, bus.bit_to_transmit, bus.all_bits_shifted, exp_seq[23-i]);
      end
      pulse_done();
    end
    total++;
    if (bus.all_bits_shifted !== 1'b1 || bus.bit_valid !== 1'b0 || bus.pixel_ready !== 1'b1 || bus.frame_done !== 1'b0) begin
      bad++;
      $display("FAIL serial_end: got ash=%0b valid=%0b ready=%0b fd=%0b expected 1 0 1 0",
               bus.all_bits_shifted, bus.bit_valid, bus.pixel_ready, bus.frame_done);
    end
    tick();
    total++;
    if (bus.all_bits_shifted !== 1'b0) begin bad++; $display("FAIL serial_ash_width: got %0b expected 0", bus.all_bits_shifted); end
    total++;
    if (ash_seen - base !== 1) begin bad++; $display("FAIL serial_ash_count: got %0d expected 1", ash_seen - base); end
    $display("test_serial: word A50FC3 done");
  endtask

  task automatic test_back_to_back();
    int base_ash, base_fd;
    logic exp_fd;
    do_reset();
    base_ash = ash_seen;
    base_fd  = fd_seen;
    for (int w = 0; w < 6; w++) begin
      load_word(24'h111111 * (w + 1));
      total++;
      if (bus.bit_valid !== 1'b1) begin bad++; $display("FAIL b2b_latency%0d: got %0b expected 1", w, bus.bit_valid); end
      for (int b = 0; b < 24; b++) pulse_done();
      exp_fd = (w == 2) || (w == 5);
      total++;
      if (bus.all_bits_shifted !== 1'b1 || bus.frame_done !== exp_fd || bus.bit_valid !== 1'b0) begin
        bad++;
        $display("FAIL b2b_word%0d: got ash=%0b fd=%0b valid=%0b expected 1 %0b 0",
                 w, bus.all_bits_shifted, bus.frame_done, bus.bit_valid, exp_fd);
      end
      $display("test_back_to_back: word %0d fd=%0b", w, bus.frame_done);
    end
    tick();
    total++;
    if (ash_seen - base_ash !== 6) begin bad++; $display("FAIL b2b_ash_count: got %0d expected 6", ash_seen - base_ash); end
    total++;
    if (fd_seen - base_fd !== 2) begin bad++; $display("FAIL b2b_fd_count: got %0d expected 2", fd_seen - base_fd); end
  endtask

  task automatic test_ignore();
    logic exp_bit;
    do_reset();
    bus.bit_done = 1'b1;
    repeat (3) tick();
    bus.bit_done = 1'b0;
    total++;
    if (bus.pixel_ready !== 1'b1 || bus.bit_valid !== 1'b0 || bus.all_bits_shifted !== 1'b0) begin
      bad++;
      $display("FAIL idle_bit_done: got ready=%0b valid=%0b ash=%0b expected 1 0 0",
               bus.pixel_ready, bus.bit_valid, bus.all_bits_shifted);
    end
    load_word(24'h800001);
    bus.pixel_data  = 24'hFFFFFF;
    bus.pixel_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      exp_bit = (i == 0) || (i == 23);
      total++;
      if (bus.pixel_ready !== 1'b0 || bus.bit_valid !== 1'b1 || bus.bit_to_transmit !== exp_bit) begin
        bad++;
        $display("FAIL ignore_bit%0d: got ready=%0b valid=%0b bit=%0b expected 0 1 %0b",
                 i, bus.pixel_ready, bus.bit_valid, bus.bit_to_transmit, exp_bit);
      end
      pulse_done();
    end
    total++;
    if (bus.pixel_ready !== 1'b1 || bus.bit_valid !== 1'b0 || bus.all_bits_shifted !== 1'b1) begin
      bad++;
      $display("FAIL final_edge_no_load: got ready=%0b valid=%0b ash=%0b expected 1 0 1",
               bus.pixel_ready, bus.bit_valid, bus.all_bits_shifted);
    end
    tick();
    bus.pixel_valid = 1'b0;
    total++;
    if (bus.bit_valid !== 1'b1 || bus.bit_to_transmit !== 1'b1 || bus.pixel_ready !== 1'b0) begin
      bad++;
      $display("FAIL final_edge_load: got valid=%0b bit=%0b ready=%0b expected 1 1 0",
               bus.bit_valid, bus.bit_to_transmit, bus.pixel_ready);
    end
    for (int b = 0; b < 24; b++) pulse_done();
    total++;
    if (bus.all_bits_shifted !== 1'b1) begin bad++; $display("FAIL ignore_drain: got %0b expected 1", bus.all_bits_shifted); end
    $display("test_ignore: done");
  endtask

  task automatic test_reset_mid();
    int base_ash, base_fd;
    do_reset();
    base_ash = ash_seen;
    base_fd  = fd_seen;
    for (int w = 0; w < 2; w++) begin
      load_word(24'h0F0F0F);
      for (int b = 0; b < 24; b++) pulse_done();
    end
    load_word(24'hFFFFFF);
    for (int b = 0; b < 12; b++) pulse_done();
    total++;
    if (bus.bit_valid !== 1'b1 || bus.bit_to_transmit !== 1'b1) begin
      bad++;
      $display("FAIL midword_live: got valid=%0b bit=%0b expected 1 1", bus.bit_valid, bus.bit_to_transmit);
    end
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if (bus.bit_valid !== 1'b0 || bus.bit_to_transmit !== 1'b0 || bus.pixel_ready !== 1'b1 ||
        bus.all_bits_shifted !== 1'b0 || bus.frame_done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got valid=%0b bit=%0b ready=%0b ash=%0b fd=%0b expected 0 0 1 0 0",
               bus.bit_valid, bus.bit_to_transmit, bus.pixel_ready, bus.all_bits_shifted, bus.frame_done);
    end
    tick();
    tick();
    rstn = 1'b1;
    tick();
    total++;
    if (ash_seen - base_ash !== 2 || fd_seen - base_fd !== 0) begin
      bad++;
      $display("FAIL reset_no_pulse: got ash=%0d fd=%0d expected 2 0", ash_seen - base_ash, fd_seen - base_fd);
    end
    base_fd = fd_seen;
    for (int w = 0; w < 3; w++) begin
      load_word(24'h00FF00 + w);
      for (int b = 0; b < 24; b++) pulse_done();
      total++;
      if (bus.frame_done !== (w == 2)) begin
        bad++;
        $display("FAIL restart_fd%0d: got %0b expected %0b", w, bus.frame_done, (w == 2));
      end
    end
    tick();
    total++;
    if (fd_seen - base_fd !== 1) begin bad++; $display("FAIL restart_fd_count: got %0d expected 1", fd_seen - base_fd); end
    $display("test_reset_mid: done");
  endtask

  initial begin
    bus.pixel_valid = 1'b0;
    bus.bit_done    = 1'b0;
    bus.pixel_data  = '0;
    test_reset();
    test_serial();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_shifter.md
PIXEL_SHIFTER -- requirements
Module: pixel_shifter

Interface
REQ-001 Parameter BITS_PER_PIXEL, default 24, number of colour bits serialised per LED (GRB order).
REQ-002 Parameter NUM_LEDS, default 64, LEDs per frame (8x8 snake matrix).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 pixel_data  input  BITS_PER_PIXEL  GRB word for next LED, MSB = G[7].
REQ-006 pixel_valid  input  1  pixel_data valid.
REQ-007 pixel_ready  output  1  shifter can accept a word; transfer when pixel_valid & pixel_ready high on the same edge.
REQ-008 bit_done  input  1  one-cycle pulse from the downstream waveform stage: current bit's high/low timing complete.
REQ-009 bit_to_transmit  output  1  current bit to encode.
REQ-010 bit_valid  output  1  bit_to_transmit holds a live bit.
REQ-011 all_bits_shifted  output  1  one-cycle pulse: last bit of current word consumed.
REQ-012 frame_done  output  1  one-cycle pulse: last bit of LED NUM_LEDS-1 consumed; downstream starts reset/latch period.

Function
REQ-013 The FSM SHALL have states IDLE and SHIFT.
REQ-014 In IDLE, pixel_ready SHALL be 1 and bit_valid 0.
REQ-015 On transfer in IDLE, the word SHALL load into the shift register, bit_cnt cleared to 0, and the FSM moves to SHIFT; bit_valid rises the cycle after the transfer edge (latency 1).
REQ-016 In SHIFT, pixel_ready SHALL be 0, bit_valid 1, bit_to_transmit = shift register MSB, stable until bit_done.
REQ-017 On bit_done in SHIFT with bit_cnt < BITS_PER_PIXEL-1, the register SHALL shift left by one (zero fill) and bit_cnt increments.
REQ-018 On bit_done in SHIFT with bit_cnt == BITS_PER_PIXEL-1, the FSM SHALL return to IDLE, and all_bits_shifted pulses high exactly one cycle, registered (the cycle after that edge).
REQ-019 pixel_cnt (width clog2(NUM_LEDS)) SHALL increment on each all_bits_shifted event; when it equals NUM_LEDS-1 at that event, it wraps to 0 and frame_done pulses in the same cycle as all_bits_shifted.
REQ-020 bit_done in IDLE SHALL be ignored (no state, counter, or output change).
REQ-021 pixel_valid while in SHIFT SHALL be ignored; data is not captured until IDLE.
REQ-022 bit_done and pixel_valid on the same edge in the final bit: no load that edge; load is possible no earlier than the next edge (pixel_ready high in IDLE).
REQ-023 Back-to-back words SHALL sustain one IDLE cycle between pixels; inter-bit gap is set only by bit_done.

Reset
REQ-024 While rstn low: FSM = IDLE, shift register = 0, bit_cnt = 0, pixel_cnt = 0, bit_to_transmit = 0, bit_valid = 0, all_bits_shifted = 0, frame_done = 0, pixel_ready = 1 after deassert.
REQ-025 Reset mid-word or mid-frame SHALL discard the partial word and restart the frame count from LED 0; no pulse outputs generated by reset.

Structure
REQ-026 BITS_PER_PIXEL and NUM_LEDS defaults and FSM state encodings SHALL live in the shared led_snake package used by the LED-strip blocks.
REQ-027 Single module, no sub-modules; bit_cnt and pixel_cnt are local counters.

Verification
REQ-028 Load 24'hA5_0F_C3, pulse bit_done every 10 cycles -> bit_to_transmit sequence 1010_0101_0000_1111_1100_0011, one all_bits_shifted pulse after 24th bit_done.
REQ-029 NUM_LEDS=3, feed 3 words back-to-back -> exactly 3 all_bits_shifted pulses, frame_done coincident with the 3rd only, pixel_cnt back to 0.
REQ-030 bit_done pulses while IDLE, pixel_valid held high during SHIFT -> no shift, no second load, pixel_ready 0 throughout SHIFT.
REQ-031 pixel_valid high on the edge of the final bit_done -> word captured one cycle later, first bit valid two cycles after that edge.
REQ-032 rstn low after bit 12 of LED 2 -> all outputs at reset values immediately; next word restarts at LED 0, frame_done after NUM_LEDS fresh words.
